// File: rtl/s_term_pkg.sv
// rtl/s_term_pkg.sv - shared FSM states and per-channel config field layout for the S terminal
package s_term_pkg;

   typedef enum logic [1:0] {
      ST_UNCONF  = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_ACTIVE  = 2'd2
   } state_e;

   localparam int CFG_FIELD_W = 3;
   localparam int DLY_OFS     = 0;
   localparam int DLY_W       = 2;
   localparam int INV_OFS     = 2;

endpackage

// File: rtl/s_term_delay_ch.sv
// rtl/s_term_delay_ch.sv - one loopback channel: 0..3 stage delay, optional invert, sync clear
module s_term_delay_ch
   import s_term_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   en,
   input  logic [CFG_FIELD_W-1:0] cfg,
   input  logic                   din,
   output logic                   dout
);

   logic [2:0]       sr_q;
   logic [2:0]       sr_d;
   logic [DLY_W-1:0] dly;
   logic             tap;

   assign dly = cfg[DLY_OFS +: DLY_W];

   always_comb begin
      sr_d = sr_q;
      if (clr) begin
         sr_d = '0;
      end else if (en) begin
         sr_d = {sr_q[1:0], din};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   // Output is forced low whenever the tile is not passing data.
   always_comb begin
      tap = 1'b0;
      case (dly)
         2'd0:    tap = din;
         2'd1:    tap = sr_q[0];
         2'd2:    tap = sr_q[1];
         default: tap = sr_q[2];
      endcase
      dout = en & (tap ^ cfg[INV_OFS]);
   end

endmodule

// File: rtl/s_term_pipe.sv
// rtl/s_term_pipe.sv - south terminal tile with configurable S-to-N loopback channels
// S_TERM_PIPE_STROBE_RETIME_EN: register FrameStrobe_O by one UserCLK cycle.
module s_term_pipe
   import s_term_pkg::*;
#(
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32,
   parameter int NUM_CH          = 8,
   parameter int CFG_FRAME       = 0
) (
   input  logic                       UserCLK,
   input  logic                       UserRST,
   input  logic [FrameBitsPerRow-1:0] FrameData,
   input  logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
   output logic                       UserCLKo,
   input  logic [NUM_CH-1:0]          S_END,
   output logic [NUM_CH-1:0]          N_BEG,
   output logic                       Co,
   output logic                       cfg_active
);

   localparam int CFG_W = CFG_FIELD_W * NUM_CH;

   state_e           state_q;
   logic             active_q;
   logic [CFG_W-1:0] cfg_q;
   logic             strobe_hist_q;
   logic             strobe_hist_d;
   logic             strobe_rise;
   logic             capture_clr;
   logic             unused_frame_bits;

   assign unused_frame_bits = ^FrameData;

   always_comb begin
      strobe_hist_d = FrameStrobe[CFG_FRAME];
      strobe_rise   = FrameStrobe[CFG_FRAME] & ~strobe_hist_q;
      capture_clr   = (state_q == ST_CAPTURE);
   end

   always_ff @(posedge UserCLK) begin
      if (UserRST) begin
         strobe_hist_q <= 1'b0;
      end else begin
         strobe_hist_q <= strobe_hist_d;
      end
   end

   // Reset is checked first so it wins over a strobe edge in the same cycle.
   always_ff @(posedge UserCLK) begin
      if (UserRST) begin
         state_q  <= ST_UNCONF;
         active_q <= 1'b0;
         cfg_q    <= '0;
      end else begin
         case (state_q)
            ST_UNCONF: begin
               if (strobe_rise) begin
                  state_q <= ST_CAPTURE;
                  cfg_q   <= FrameData[CFG_W-1:0];
               end
            end
            ST_CAPTURE: begin
               state_q  <= ST_ACTIVE;
               active_q <= 1'b1;
            end
            ST_ACTIVE: begin
               if (strobe_rise) begin
                  state_q  <= ST_CAPTURE;
                  active_q <= 1'b0;
                  cfg_q    <= FrameData[CFG_W-1:0];
               end
            end
            default: begin
               state_q  <= ST_UNCONF;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      s_term_delay_ch u_ch (
         .clk  (UserCLK),
         .rst  (UserRST),
         .clr  (capture_clr),
         .en   (active_q),
         .cfg  (cfg_q[i*CFG_FIELD_W +: CFG_FIELD_W]),
         .din  (S_END[i]),
         .dout (N_BEG[i])
      );
   end

`ifdef S_TERM_PIPE_STROBE_RETIME_EN
   logic [MaxFramesPerCol-1:0] strobe_o_q;
   logic [MaxFramesPerCol-1:0] strobe_o_d;

   always_comb begin
      strobe_o_d = FrameStrobe;
   end

   always_ff @(posedge UserCLK) begin
      if (UserRST) begin
         strobe_o_q <= '0;
      end else begin
         strobe_o_q <= strobe_o_d;
      end
   end

   assign FrameStrobe_O = strobe_o_q;
`else
   for (genvar j = 0; j < MaxFramesPerCol; j++) begin : g_strobe_buf
      assign FrameStrobe_O[j] = FrameStrobe[j];
   end
`endif

   assign UserCLKo   = UserCLK;
   assign Co         = 1'b0;
   assign cfg_active = active_q;

endmodule
